// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDR SDRAM controller engines: command
//   encodings on {CS_n,RAS_n,CAS_n,WE_n}, the self-refresh sequencer state
//   type, the A10 all-banks mask and small timing helpers.
//   No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

  // SDRAM command encodings, {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  // AUTO REFRESH and SELF REFRESH share this encoding; CKE selects which.
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;

  // A10 high on PRECHARGE selects all banks.
  localparam logic [11:0] ADDR_A10_ALL_BANKS = 12'h400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    TRP   = 3'd2,
    ENTRY = 3'd3,
    HOLD  = 3'd4,
    EXIT  = 3'd5,
    DONE  = 3'd6
  } sr_state_e;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // The wait timer counts down to 0 and the owning state leaves on the
  // cycle it reads 0, so a wait of N cycles loads N-1. Zero and one both
  // map to a single cycle.
  function automatic int unsigned timer_load(input int unsigned cycles);
    return (cycles > 0) ? cycles - 1 : 0;
  endfunction

  // Counter width able to hold the largest wait; never narrower than 1 bit.
  function automatic int unsigned timer_width(input int unsigned max_cycles);
    return (max_cycles < 1) ? 1 : $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// -----------------------------------------------------------------------------
// sdram_wait_timer
//   Loadable down-counter used to time SDRAM command spacing. Loading takes
//   priority; otherwise the count decrements and saturates at zero.
//   Ports:
//     clk_i      clock
//     srst_i     synchronous active-high reset (count -> 0)
//     load_i     load value_i this cycle
//     value_i    value to load
//     expired_o  count is zero
// -----------------------------------------------------------------------------
module sdram_wait_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         expired_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/sdram_self_refresh_ctrl.sv
// -----------------------------------------------------------------------------
// sdram_self_refresh_ctrl
//   SDR SDRAM self-refresh sequencer. On request it precharges all banks,
//   waits tRP, issues SELF REFRESH with CKE low and holds the device there
//   for at least T_SRMIN cycles and until released. On release it raises
//   CKE, issues NOPs for tXSR and pulses self_ref_done for one cycle.
//   Ports:
//     sys_clk        system clock, rising edge
//     sys_rst        synchronous active-high reset
//     self_ref_en    level request: 1 = enter/stay, 0 = exit
//     sdram_init     power-up init complete; gates entry from IDLE only
//     sdram_cke      SDRAM clock enable (registered)
//     sdram_cmd      {CS_n,RAS_n,CAS_n,WE_n} (registered)
//     sdram_ba       bank address (registered)
//     sdram_addr     address bus (registered)
//     self_ref_done  one-cycle pulse at the end of the exit sequence
// -----------------------------------------------------------------------------
module sdram_self_refresh_ctrl
  import sdram_pkg::*;
#(
  parameter int unsigned T_RP    = 2,
  parameter int unsigned T_SRMIN = 5,
  parameter int unsigned T_XSR   = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        self_ref_en,
  input  logic        sdram_init,
  output logic        sdram_cke,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_ba,
  output logic [11:0] sdram_addr,
  output logic        self_ref_done
);

  localparam int unsigned TW = timer_width(max3(T_RP, T_SRMIN, T_XSR));

  localparam logic [TW-1:0] LOAD_RP    = TW'(timer_load(T_RP));
  localparam logic [TW-1:0] LOAD_SRMIN = TW'(timer_load(T_SRMIN));
  localparam logic [TW-1:0] LOAD_XSR   = TW'(timer_load(T_XSR));

  sr_state_e       state_q, state_d;
  logic            timer_load_d;
  logic [TW-1:0]   timer_value_d;
  logic            timer_expired;

  logic            cke_q;
  logic [3:0]      cmd_q;
  logic [1:0]      ba_q;
  logic [11:0]     addr_q;
  logic            done_q;

  sdram_wait_timer #(
    .W (TW)
  ) u_timer (
    .clk_i     (sys_clk),
    .srst_i    (sys_rst),
    .load_i    (timer_load_d),
    .value_i   (timer_value_d),
    .expired_o (timer_expired)
  );

  // Next-state decision and timer loads. The timer is loaded on the
  // transition into a timed state so it reads the full count during that
  // state's first cycle.
  always_comb begin
    state_d       = state_q;
    timer_load_d  = 1'b0;
    timer_value_d = '0;
    case (state_q)
      IDLE: begin
        if (self_ref_en && sdram_init) begin
          state_d = PRE;
        end
      end
      PRE: begin
        state_d       = TRP;
        timer_load_d  = 1'b1;
        timer_value_d = LOAD_RP;
      end
      TRP: begin
        if (timer_expired) begin
          state_d       = ENTRY;
          // The minimum self-refresh residency is measured from ENTRY, so
          // the count starts here and keeps running through HOLD.
          timer_load_d  = 1'b1;
          timer_value_d = LOAD_SRMIN;
        end
      end
      ENTRY: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (timer_expired && !self_ref_en) begin
          state_d       = EXIT;
          timer_load_d  = 1'b1;
          timer_value_d = LOAD_XSR;
        end
      end
      EXIT: begin
        if (timer_expired) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and pin registers. Pins are decoded from the next state so they
  // change on the same edge as the state they belong to.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cke_q   <= 1'b1;
      cmd_q   <= CMD_NOP;
      ba_q    <= 2'b00;
      addr_q  <= 12'h000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cke_q   <= 1'b1;
      cmd_q   <= CMD_NOP;
      ba_q    <= 2'b00;
      addr_q  <= 12'h000;
      done_q  <= 1'b0;
      case (state_d)
        PRE: begin
          cmd_q  <= CMD_PRECHARGE;
          addr_q <= ADDR_A10_ALL_BANKS;
        end
        ENTRY: begin
          // SELF REFRESH is REFRESH with CKE dropping in the same cycle.
          cmd_q <= CMD_REFRESH;
          cke_q <= 1'b0;
        end
        HOLD: begin
          cke_q <= 1'b0;
        end
        DONE: begin
          done_q <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign sdram_cke     = cke_q;
  assign sdram_cmd     = cmd_q;
  assign sdram_ba      = ba_q;
  assign sdram_addr    = addr_q;
  assign self_ref_done = done_q;

endmodule

// File: tb/tb_sdram_self_refresh_ctrl.sv
`timescale 1ns/1ps
module tb_sdram_self_refresh_ctrl;

  localparam int T_RP    = 2;
  localparam int T_SRMIN = 5;
  localparam int T_XSR   = 8;
  localparam int RP_CYC  = (T_RP  < 1) ? 1 : T_RP;
  localparam int XSR_CYC = (T_XSR < 1) ? 1 : T_XSR;

  localparam logic [3:0]  C_NOP  = 4'b0111;
  localparam logic [3:0]  C_PRE  = 4'b0010;
  localparam logic [3:0]  C_REF  = 4'b0001;

  // Packed view of all pins: {cke, cmd, ba, addr, done}
  typedef struct packed {
    logic        cke;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
    logic        done;
  } pins_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        init;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [1:0]  sdram_ba;
  logic [11:0] sdram_addr;
  logic        self_ref_done;

  int n_cmp;
  int n_fail;

  sdram_self_refresh_ctrl #(
    .T_RP    (T_RP),
    .T_SRMIN (T_SRMIN),
    .T_XSR   (T_XSR)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .self_ref_en   (en),
    .sdram_init    (init),
    .sdram_cke     (sdram_cke),
    .sdram_cmd     (sdram_cmd),
    .sdram_ba      (sdram_ba),
    .sdram_addr    (sdram_addr),
    .self_ref_done (self_ref_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Reference model: expected pin sequences are queued as whole segments
  // (entry burst, exit burst); only the open-ended hold phase is decided
  // cycle by cycle from the request level and cycles spent with CKE low.
  // ---------------------------------------------------------------------------
  function automatic pins_t mk(input logic cke, input logic [3:0] cmd,
                               input logic [11:0] addr, input logic done);
    pins_t p;
    p.cke = cke; p.cmd = cmd; p.ba = 2'b00; p.addr = addr; p.done = done;
    return p;
  endfunction

  pins_t exp_q[$];
  pins_t exp;
  pins_t act;
  bit    in_hold;
  int    low_cnt;

  function automatic pins_t dut_pins();
    return {sdram_cke, sdram_cmd, sdram_ba, sdram_addr, self_ref_done};
  endfunction

  function automatic bit model_idle();
    return (exp_q.size() == 0) && !in_hold;
  endfunction

  // Advance one clock; the model consumes the inputs the DUT sees at the
  // same edge, then we move 1ns past the edge for sampling.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      in_hold = 1'b0;
      exp = mk(1'b1, C_NOP, 12'h000, 1'b0);
    end else if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (exp.cmd == C_REF && exp.cke == 1'b0) begin
        in_hold = 1'b1;
        low_cnt = 1;
      end
    end else if (in_hold) begin
      if (!en && low_cnt >= T_SRMIN) begin
        in_hold = 1'b0;
        exp = mk(1'b1, C_NOP, 12'h000, 1'b0);
        for (int i = 1; i < XSR_CYC; i++) exp_q.push_back(mk(1'b1, C_NOP, 12'h000, 1'b0));
        exp_q.push_back(mk(1'b1, C_NOP, 12'h000, 1'b1));
        exp_q.push_back(mk(1'b1, C_NOP, 12'h000, 1'b0)); // mandatory idle cycle
      end else begin
        exp = mk(1'b0, C_NOP, 12'h000, 1'b0);
        low_cnt++;
      end
    end else if (en && init) begin
      exp = mk(1'b1, C_PRE, 12'h400, 1'b0);
      for (int i = 0; i < RP_CYC; i++) exp_q.push_back(mk(1'b1, C_NOP, 12'h000, 1'b0));
      exp_q.push_back(mk(1'b0, C_REF, 12'h000, 1'b0));
    end else begin
      exp = mk(1'b1, C_NOP, 12'h000, 1'b0);
    end
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; init = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp || act !== mk(1'b1, C_NOP, 12'h000, 1'b0)) begin
        n_fail++;
        $display("FAIL reset cyc=%0d pins got=%h want=%h", c, act, exp);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc=%0d pins got=%h want=%h", c, act, exp);
      end
    end
    $display("test_reset: done");
  endtask

  // en high for 15 cycles, then released; full entry and exit
  task automatic test_basic();
    int low_run, done_cnt, since_rise;
    bit seen_low, finished;
    low_run = 0; done_cnt = 0; since_rise = 0; seen_low = 0; finished = 0;
    init = 1'b1;
    for (int c = 0; c < 80 && !finished; c++) begin
      en = (c < 15);
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL basic cyc=%0d pins got=%h want=%h", c, act, exp);
      end
      if (c == 0) begin
        n_cmp++;
        if (act.cmd !== C_PRE || act.addr !== 12'h400 || act.ba !== 2'b00) begin
          n_fail++;
          $display("FAIL basic_precharge cmd=%b addr=%h ba=%0d want cmd=%b addr=400 ba=0",
                   act.cmd, act.addr, act.ba, C_PRE);
        end
      end
      if (act.cke === 1'b0) begin low_run++; seen_low = 1; since_rise = 0; end
      else if (seen_low && !act.done) since_rise++;
      if (act.done === 1'b1) begin
        done_cnt++;
        n_cmp++;
        if (since_rise != T_XSR) begin
          n_fail++;
          $display("FAIL basic_exit_nops got=%0d want=%0d", since_rise, T_XSR);
        end
      end
      if (done_cnt > 0 && model_idle()) finished = 1;
    end
    n_cmp++;
    if (done_cnt != 1 || low_run < T_SRMIN || !finished) begin
      n_fail++;
      $display("FAIL basic_summary done_pulses=%0d cke_low=%0d finished=%0d want 1 / >=%0d / 1",
               done_cnt, low_run, finished, T_SRMIN);
    end
    $display("test_basic: cke low %0d cycles, done pulses %0d", low_run, done_cnt);
  endtask

  // en high for only 2 cycles still completes entry and honours T_SRMIN
  task automatic test_short_request();
    int low_run, done_cnt;
    bit finished;
    low_run = 0; done_cnt = 0; finished = 0;
    init = 1'b1;
    for (int c = 0; c < 60 && !finished; c++) begin
      en = (c < 2);
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL short cyc=%0d pins got=%h want=%h", c, act, exp);
      end
      if (act.cke === 1'b0) low_run++;
      if (act.done === 1'b1) done_cnt++;
      if (done_cnt > 0 && model_idle()) finished = 1;
    end
    n_cmp++;
    if (low_run < T_SRMIN || done_cnt != 1 || !finished) begin
      n_fail++;
      $display("FAIL short_summary cke_low=%0d done_pulses=%0d finished=%0d want >=%0d / 1 / 1",
               low_run, done_cnt, finished, T_SRMIN);
    end
    $display("test_short_request: cke low %0d cycles", low_run);
  endtask

  // init low blocks entry; raising it starts PRECHARGE on the next cycle
  task automatic test_init_gate();
    bit finished;
    finished = 0;
    init = 1'b0; en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp || act.cmd !== C_NOP || act.cke !== 1'b1) begin
        n_fail++;
        $display("FAIL init_block cyc=%0d pins got=%h want=%h", c, act, exp);
      end
    end
    init = 1'b1;
    tick();
    act = dut_pins();
    n_cmp++;
    if (act !== exp || act.cmd !== C_PRE || act.addr !== 12'h400) begin
      n_fail++;
      $display("FAIL init_release pins got=%h want=%h", act, exp);
    end
    en = 1'b0;
    for (int c = 0; c < 60 && !finished; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL init_seq cyc=%0d pins got=%h want=%h", c, act, exp);
      end
      if (model_idle()) finished = 1;
    end
    n_cmp++;
    if (!finished) begin
      n_fail++;
      $display("FAIL init_timeout sequence did not return to idle within 60 cycles");
    end
    $display("test_init_gate: done");
  endtask

  // reset while in self refresh: pins return to idle values next edge
  task automatic test_reset_in_hold();
    int low_run;
    low_run = 0;
    init = 1'b1; en = 1'b1;
    for (int c = 0; c < 30 && low_run < 3; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL hold_entry cyc=%0d pins got=%h want=%h", c, act, exp);
      end
      if (act.cke === 1'b0) low_run++;
    end
    n_cmp++;
    if (low_run < 3) begin
      n_fail++;
      $display("FAIL hold_reach cke_low=%0d want 3", low_run);
    end
    rst = 1'b1;
    tick();
    act = dut_pins();
    n_cmp++;
    if (act !== exp || act !== mk(1'b1, C_NOP, 12'h000, 1'b0)) begin
      n_fail++;
      $display("FAIL hold_reset pins got=%h want=%h", act, exp);
    end
    rst = 1'b0; en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp || act.done !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_after_reset cyc=%0d pins got=%h want=%h", c, act, exp);
      end
    end
    $display("test_reset_in_hold: done");
  endtask

  // request reasserted during exit: exit and done complete, then re-entry
  task automatic test_back_to_back();
    int done_cnt, pre_cnt;
    bit finished;
    done_cnt = 0; pre_cnt = 0; finished = 0;
    init = 1'b1;
    for (int c = 0; c < 120 && !finished; c++) begin
      en = (c < 3) || (c >= 10 && c < 30);
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL b2b cyc=%0d pins got=%h want=%h", c, act, exp);
      end
      if (act.done === 1'b1) done_cnt++;
      if (act.cmd === C_PRE) pre_cnt++;
      if (c >= 30 && done_cnt == 2 && model_idle()) finished = 1;
    end
    n_cmp++;
    if (done_cnt != 2 || pre_cnt != 2 || !finished) begin
      n_fail++;
      $display("FAIL b2b_summary done_pulses=%0d precharges=%0d finished=%0d want 2 / 2 / 1",
               done_cnt, pre_cnt, finished);
    end
    $display("test_back_to_back: done pulses %0d", done_cnt);
  endtask

  // randomized request/init/reset traffic against the model, plus the rule
  // that only NOP may be issued while CKE stays low after the entry cycle
  task automatic test_random();
    logic prev_cke;
    int   cyc_fail;
    prev_cke = 1'b1; cyc_fail = 0;
    rst = 1'b0; en = 1'b0; init = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      init = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 299) == 0);
      tick();
      act = dut_pins();
      n_cmp++;
      if (act !== exp) begin
        n_fail++; cyc_fail++;
        $display("FAIL random cyc=%0d en=%0d init=%0d rst=%0d pins got=%h want=%h",
                 c, en, init, rst, act, exp);
      end
      if (prev_cke === 1'b0 && act.cke === 1'b0) begin
        n_cmp++;
        if (act.cmd !== C_NOP) begin
          n_fail++; cyc_fail++;
          $display("FAIL random_cke_low_cmd cyc=%0d cmd=%b want %b", c, act.cmd, C_NOP);
        end
      end
      prev_cke = act.cke;
      if (cyc_fail > 20) break;
    end
    rst = 1'b0;
    $display("test_random: done");
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    in_hold = 1'b0; low_cnt = 0;
    rst = 1'b1; en = 1'b0; init = 1'b1;
    test_reset();
    test_basic();
    test_short_request();
    test_init_gate();
    test_reset_in_hold();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
